// File: rtl/cpu_isa_pkg.sv
// ---------------------------------------------------------------------------
// cpu_isa_pkg
// Shared ISA definitions for the 16-bit minesweeper CPU.
//   - Opcode constants (instruction bits [15:12])
//   - Instruction memory geometry and default program-counter width
//   - Fetch FSM state type
//   - Small decode helpers used by the fetch front end
// ---------------------------------------------------------------------------
package cpu_isa_pkg;

  // Opcode field, instruction bits [15:12]
  localparam logic [3:0] OP_JUMP  = 4'b0001;
  localparam logic [3:0] OP_LB    = 4'b0010;
  localparam logic [3:0] OP_SB    = 4'b0100;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_ORI   = 4'b0111;
  localparam logic [3:0] OP_BEQ   = 4'b1000;
  localparam logic [3:0] OP_BNE   = 4'b1001;
  localparam logic [3:0] OP_BGEZ  = 4'b1010;
  localparam logic [3:0] OP_BLTZ  = 4'b1011;
  localparam logic [3:0] OP_RTYPE = 4'b1111;

  // Instruction RAM holds 512 16-bit words, addressed by byte address,
  // so the default byte-address width is 10 bits.
  localparam int IMEM_WORDS = 512;
  localparam int PC_W_DEF   = 10;

  // A JUMP carries a 9-bit word target in [8:0]; [11:9] must be zero.
  localparam int JUMP_TGT_W = 9;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  function automatic logic [3:0] opcode_of(input logic [15:0] word);
    return word[15:12];
  endfunction

  function automatic logic is_jump_op(input logic [15:0] word);
    return opcode_of(word) == OP_JUMP;
  endfunction

endpackage

// File: rtl/jump_predecode.sv
// ---------------------------------------------------------------------------
// jump_predecode
// Combinational pre-decode of the word currently returned by instruction RAM,
// so the fetch unit can follow a JUMP in the same cycle it captures it.
//
// Ports:
//   word_i        in  16    instruction word from instruction RAM
//   pc_i          in  PC_W  byte address the word was fetched from
//   is_jump_o     out 1     word is a JUMP (opcode 0001)
//   target_o      out PC_W  JUMP target byte address ({word[8:0],1'b0})
//   bad_target_o  out 1     JUMP with nonzero bits [11:9] (ignored by target)
//   self_loop_o   out 1     JUMP whose target word is its own word
// ---------------------------------------------------------------------------
module jump_predecode
  import cpu_isa_pkg::*;
#(
  parameter int PC_W = PC_W_DEF
) (
  input  logic [15:0]     word_i,
  input  logic [PC_W-1:0] pc_i,
  output logic            is_jump_o,
  output logic [PC_W-1:0] target_o,
  output logic            bad_target_o,
  output logic            self_loop_o
);

  // Word target is 9 bits; the byte address is that shifted left once.
  logic [JUMP_TGT_W:0] target_raw;

  assign is_jump_o  = is_jump_op(word_i);
  assign target_raw = {word_i[JUMP_TGT_W-1:0], 1'b0};
  assign target_o   = PC_W'(target_raw);

  // Upper target bits are silently masked; flag it so software bugs surface.
  assign bad_target_o = is_jump_o && (word_i[11:9] != 3'b000);

  // Both addresses are even, so compare word indices only.
  assign self_loop_o = is_jump_o && (target_o[PC_W-1:1] == pc_i[PC_W-1:1]);

  // PC bit 0 is always zero and carries no information here.
  logic unused_pc_lsb;
  assign unused_pc_lsb = pc_i[0];

endmodule

// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit
// Instruction-fetch front end. Owns the PC, addresses instruction RAM and
// captures the returned word into a single IF/ID register with a
// valid/ready handshake toward decode. JUMPs are followed locally without a
// bubble; taken branches arrive as redirects from execute and flush the
// IF/ID register. A JUMP to itself (idle loop) parks the unit in HALT.
//
// Ports:
//   CLK             in  1     clock, rising edge
//   RESET           in  1     synchronous active-high reset
//   IMEM_ADDR       out PC_W  byte address to instruction RAM (== PC)
//   IMEM_Q          in  16    instruction word for IMEM_ADDR, same cycle
//   REDIRECT_VALID  in  1     execute requests a PC change
//   REDIRECT_ADDR   in  PC_W  new byte address (bit 0 ignored)
//   ID_READY        in  1     decode accepts INSTR this cycle
//   INSTR           out 16    fetched instruction
//   INSTR_PC        out PC_W  byte address of INSTR
//   INSTR_VALID     out 1     INSTR/INSTR_PC valid
//   HALTED          out 1     self-loop JUMP fetched, fetching stopped
//   BAD_JUMP        out 1     sticky: a JUMP had nonzero target bits [11:9]
// ---------------------------------------------------------------------------
module ifetch_unit
  import cpu_isa_pkg::*;
#(
  parameter int PC_W     = PC_W_DEF,
  parameter int RESET_PC = 0
) (
  input  logic            CLK,
  input  logic            RESET,
  output logic [PC_W-1:0] IMEM_ADDR,
  input  logic [15:0]     IMEM_Q,
  input  logic            REDIRECT_VALID,
  input  logic [PC_W-1:0] REDIRECT_ADDR,
  input  logic            ID_READY,
  output logic [15:0]     INSTR,
  output logic [PC_W-1:0] INSTR_PC,
  output logic            INSTR_VALID,
  output logic            HALTED,
  output logic            BAD_JUMP
);

  localparam logic [PC_W-1:0] RESET_PC_L = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] PC_STEP    = PC_W'(2);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     instr_q, instr_d;
  logic [PC_W-1:0] instr_pc_q, instr_pc_d;
  logic            valid_q, valid_d;
  logic            bad_jump_q, bad_jump_d;

  // -------------------------------------------------------------------------
  // Pre-decode of the word on IMEM_Q
  // -------------------------------------------------------------------------
  logic            pd_is_jump;
  logic [PC_W-1:0] pd_target;
  logic            pd_bad_target;
  logic            pd_self_loop;

  jump_predecode #(
    .PC_W (PC_W)
  ) u_jump_predecode (
    .word_i       (IMEM_Q),
    .pc_i         (pc_q),
    .is_jump_o    (pd_is_jump),
    .target_o     (pd_target),
    .bad_target_o (pd_bad_target),
    .self_loop_o  (pd_self_loop)
  );

  // -------------------------------------------------------------------------
  // Control
  // -------------------------------------------------------------------------
  logic halted;
  logic adv;

  assign halted = (state_q == ST_HALT);
  // Capture when not parked and the IF/ID slot is empty or being drained.
  assign adv    = !halted && (!valid_q || ID_READY);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    bad_jump_d = bad_jump_q;

    if (REDIRECT_VALID) begin
      // Flush: the word on IMEM_Q belongs to the wrong path and is dropped.
      // Any word held in IF/ID is discarded whether or not decode took it.
      pc_d    = {REDIRECT_ADDR[PC_W-1:1], 1'b0};
      valid_d = 1'b0;
      state_d = ST_RUN;
    end else if (adv) begin
      instr_d    = IMEM_Q;
      instr_pc_d = pc_q;
      valid_d    = 1'b1;
      if (pd_is_jump) begin
        if (pd_bad_target) begin
          bad_jump_d = 1'b1;
        end
        if (pd_self_loop) begin
          // Deliver the loop word once, then stop; PC stays on it.
          state_d = ST_HALT;
        end else begin
          pc_d = pd_target;
        end
      end else begin
        pc_d = pc_q + PC_STEP;
      end
    end else if (halted && valid_q && ID_READY) begin
      // Parked: let decode drain the final word, then stay empty.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_RUN;
      pc_q       <= {RESET_PC_L[PC_W-1:1], 1'b0};
      instr_q    <= 16'h0000;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      bad_jump_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      bad_jump_q <= bad_jump_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // Address depends on PC only, keeping IMEM_Q -> IMEM_ADDR free of loops.
  assign IMEM_ADDR   = pc_q;
  assign INSTR       = instr_q;
  assign INSTR_PC    = instr_pc_q;
  assign INSTR_VALID = valid_q;
  assign HALTED      = halted;
  assign BAD_JUMP    = bad_jump_q;

  // Redirect bit 0 is forced to zero and otherwise unused.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = REDIRECT_ADDR[0];

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

  localparam int PC_W = 10;

  logic            CLK = 1'b0;
  logic            RESET = 1'b1;
  logic [PC_W-1:0] IMEM_ADDR;
  logic [15:0]     IMEM_Q;
  logic            REDIRECT_VALID = 1'b0;
  logic [PC_W-1:0] REDIRECT_ADDR = '0;
  logic            ID_READY = 1'b0;
  logic [15:0]     INSTR;
  logic [PC_W-1:0] INSTR_PC;
  logic            INSTR_VALID;
  logic            HALTED;
  logic            BAD_JUMP;

  int n_checks = 0;
  int n_fail   = 0;

  // Instruction RAM model: combinational read by word index.
  logic [15:0] mem [0:511];
  assign IMEM_Q = mem[IMEM_ADDR[9:1]];

  always #5 CLK = ~CLK;

  ifetch_unit #(.PC_W(PC_W), .RESET_PC(0)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .IMEM_ADDR      (IMEM_ADDR),
    .IMEM_Q         (IMEM_Q),
    .REDIRECT_VALID (REDIRECT_VALID),
    .REDIRECT_ADDR  (REDIRECT_ADDR),
    .ID_READY       (ID_READY),
    .INSTR          (INSTR),
    .INSTR_PC       (INSTR_PC),
    .INSTR_VALID    (INSTR_VALID),
    .HALTED         (HALTED),
    .BAD_JUMP       (BAD_JUMP)
  );

  // Default program: R-type words, never a JUMP; low bits tag the word index.
  task automatic fill_mem();
    for (int i = 0; i < 512; i++) mem[i] = 16'hF000 | 16'(i);
  endtask

  // Advance one clock and settle 1 time unit past the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
    $display("t=%0t addr=%h instr=%h ipc=%h v=%0b halt=%0b bad=%0b",
             $time, IMEM_ADDR, INSTR, INSTR_PC, INSTR_VALID, HALTED, BAD_JUMP);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    REDIRECT_VALID = 1'b0;
    ID_READY = 1'b1;
    repeat (3) tick();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    fill_mem();
    RESET = 1'b1;
    repeat (3) tick();
    n_checks++; if (IMEM_ADDR !== 10'h000) begin n_fail++; $display("FAIL reset_addr got %h exp 000", IMEM_ADDR); end
    n_checks++; if (INSTR_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", INSTR_VALID); end
    n_checks++; if (INSTR !== 16'h0000) begin n_fail++; $display("FAIL reset_instr got %h exp 0000", INSTR); end
    n_checks++; if (INSTR_PC !== 10'h000) begin n_fail++; $display("FAIL reset_ipc got %h exp 000", INSTR_PC); end
    n_checks++; if (HALTED !== 1'b0 || BAD_JUMP !== 1'b0) begin n_fail++; $display("FAIL reset_flags got %b%b exp 00", HALTED, BAD_JUMP); end
  endtask

  task automatic test_straight();
    logic [PC_W-1:0] exp_pc [4];
    exp_pc = '{10'h000, 10'h002, 10'h004, 10'h006};
    fill_mem();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (INSTR_VALID !== 1'b1 || INSTR_PC !== exp_pc[k] || INSTR !== (16'hF000 | 16'(k))) begin
        n_fail++;
        $display("FAIL straight[%0d] got v=%b pc=%h i=%h exp v=1 pc=%h i=%h",
                 k, INSTR_VALID, INSTR_PC, INSTR, exp_pc[k], 16'hF000 | 16'(k));
      end
    end
    n_checks++; if (IMEM_ADDR !== 10'h008) begin n_fail++; $display("FAIL straight_addr got %h exp 008", IMEM_ADDR); end
  endtask

  task automatic test_jump();
    fill_mem();
    mem[10] = 16'h1021;
    do_reset();
    repeat (11) tick();
    n_checks++; if (INSTR_PC !== 10'h014 || INSTR !== 16'h1021) begin n_fail++; $display("FAIL jump_word got pc=%h i=%h exp 014/1021", INSTR_PC, INSTR); end
    n_checks++; if (IMEM_ADDR !== 10'h042) begin n_fail++; $display("FAIL jump_addr got %h exp 042", IMEM_ADDR); end
    tick();
    n_checks++; if (INSTR_PC !== 10'h042 || INSTR !== 16'hF021 || INSTR_VALID !== 1'b1) begin n_fail++; $display("FAIL jump_target got pc=%h i=%h v=%b exp 042/F021/1", INSTR_PC, INSTR, INSTR_VALID); end
    tick();
    n_checks++; if (INSTR_PC !== 10'h044) begin n_fail++; $display("FAIL jump_after got %h exp 044", INSTR_PC); end
  endtask

  task automatic test_back_to_back();
    fill_mem();
    mem[0] = 16'h1005;
    mem[5] = 16'h1002;
    do_reset();
    tick();
    n_checks++; if (INSTR_PC !== 10'h000) begin n_fail++; $display("FAIL b2b_0 got %h exp 000", INSTR_PC); end
    tick();
    n_checks++; if (INSTR_PC !== 10'h00A) begin n_fail++; $display("FAIL b2b_1 got %h exp 00a", INSTR_PC); end
    tick();
    n_checks++; if (INSTR_PC !== 10'h004 || INSTR !== 16'hF002) begin n_fail++; $display("FAIL b2b_2 got %h/%h exp 004/F002", INSTR_PC, INSTR); end
  endtask

  task automatic test_stall_redirect();
    fill_mem();
    do_reset();
    repeat (3) tick();
    ID_READY = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (INSTR_PC !== 10'h004 || INSTR !== 16'hF002 || IMEM_ADDR !== 10'h006 || INSTR_VALID !== 1'b1) begin
        n_fail++;
        $display("FAIL stall[%0d] got pc=%h i=%h a=%h v=%b exp 004/F002/006/1", k, INSTR_PC, INSTR, IMEM_ADDR, INSTR_VALID);
      end
    end
    ID_READY = 1'b1;
    tick();
    n_checks++; if (INSTR_PC !== 10'h006) begin n_fail++; $display("FAIL stall_resume got %h exp 006", INSTR_PC); end
    // Redirect while decode is stalled
    ID_READY = 1'b0;
    REDIRECT_VALID = 1'b1;
    REDIRECT_ADDR = 10'h03F;
    tick();
    REDIRECT_VALID = 1'b0;
    n_checks++; if (INSTR_VALID !== 1'b0 || IMEM_ADDR !== 10'h03E) begin n_fail++; $display("FAIL redirect_flush got v=%b a=%h exp 0/03e", INSTR_VALID, IMEM_ADDR); end
    tick();
    n_checks++; if (INSTR_VALID !== 1'b1 || INSTR_PC !== 10'h03E || INSTR !== 16'hF01F) begin n_fail++; $display("FAIL redirect_fetch got v=%b pc=%h i=%h exp 1/03e/F01F", INSTR_VALID, INSTR_PC, INSTR); end
  endtask

  task automatic test_wrap();
    fill_mem();
    do_reset();
    REDIRECT_VALID = 1'b1;
    REDIRECT_ADDR = 10'h3FE;
    tick();
    REDIRECT_VALID = 1'b0;
    tick();
    n_checks++; if (INSTR_PC !== 10'h3FE || IMEM_ADDR !== 10'h000) begin n_fail++; $display("FAIL wrap got pc=%h a=%h exp 3fe/000", INSTR_PC, IMEM_ADDR); end
  endtask

  task automatic test_halt();
    fill_mem();
    mem[157] = 16'h109D;
    do_reset();
    REDIRECT_VALID = 1'b1;
    REDIRECT_ADDR = 10'h13A;
    tick();
    REDIRECT_VALID = 1'b0;
    ID_READY = 1'b0;
    tick();
    n_checks++; if (INSTR_VALID !== 1'b1 || INSTR_PC !== 10'h13A || HALTED !== 1'b1) begin n_fail++; $display("FAIL halt_enter got v=%b pc=%h h=%b exp 1/13a/1", INSTR_VALID, INSTR_PC, HALTED); end
    n_checks++; if (IMEM_ADDR !== 10'h13A) begin n_fail++; $display("FAIL halt_addr got %h exp 13a", IMEM_ADDR); end
    tick();
    n_checks++; if (INSTR_VALID !== 1'b1) begin n_fail++; $display("FAIL halt_hold got v=%b exp 1", INSTR_VALID); end
    ID_READY = 1'b1;
    tick();
    n_checks++; if (INSTR_VALID !== 1'b0 || HALTED !== 1'b1) begin n_fail++; $display("FAIL halt_drain got v=%b h=%b exp 0/1", INSTR_VALID, HALTED); end
    tick();
    n_checks++; if (INSTR_VALID !== 1'b0 || IMEM_ADDR !== 10'h13A) begin n_fail++; $display("FAIL halt_idle got v=%b a=%h exp 0/13a", INSTR_VALID, IMEM_ADDR); end
    REDIRECT_VALID = 1'b1;
    REDIRECT_ADDR = 10'h000;
    tick();
    REDIRECT_VALID = 1'b0;
    n_checks++; if (HALTED !== 1'b0 || IMEM_ADDR !== 10'h000) begin n_fail++; $display("FAIL halt_exit got h=%b a=%h exp 0/000", HALTED, IMEM_ADDR); end
    tick();
    n_checks++; if (INSTR_VALID !== 1'b1 || INSTR_PC !== 10'h000) begin n_fail++; $display("FAIL halt_refetch got v=%b pc=%h exp 1/000", INSTR_VALID, INSTR_PC); end
  endtask

  task automatic test_bad_jump();
    fill_mem();
    mem[0] = 16'h1E05;
    do_reset();
    tick();
    n_checks++; if (BAD_JUMP !== 1'b1 || IMEM_ADDR !== 10'h00A) begin n_fail++; $display("FAIL bad_jump got b=%b a=%h exp 1/00a", BAD_JUMP, IMEM_ADDR); end
    tick();
    n_checks++; if (BAD_JUMP !== 1'b1 || INSTR_PC !== 10'h00A) begin n_fail++; $display("FAIL bad_sticky got b=%b pc=%h exp 1/00a", BAD_JUMP, INSTR_PC); end
    ID_READY = 1'b0;
    tick();
    RESET = 1'b1;
    tick();
    n_checks++;
    if (INSTR_VALID !== 1'b0 || INSTR !== 16'h0000 || INSTR_PC !== 10'h000 || IMEM_ADDR !== 10'h000 || HALTED !== 1'b0 || BAD_JUMP !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset got v=%b i=%h pc=%h a=%h h=%b b=%b exp all zero", INSTR_VALID, INSTR, INSTR_PC, IMEM_ADDR, HALTED, BAD_JUMP);
    end
    RESET = 1'b0;
  endtask

  initial begin
    test_reset();
    test_straight();
    test_jump();
    test_back_to_back();
    test_stall_redirect();
    test_wrap();
    test_halt();
    test_bad_jump();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction-fetch initiator for the 16-bit minesweeper CPU. It owns the program counter, drives the byte address into the instruction RAM and captures the returned word into a single IF/ID register with a valid/ready handshake toward decode. JUMP (opcode 0001) is resolved locally, with no bubble. Branch and other redirects come from execute and flush the fetch register. A self-loop JUMP (game_won / game_dead idle) is detected and stops fetching.

Parameters:
PC_W, 10, byte-address width driven to instruction RAM (word index = addr[PC_W-1:1])
RESET_PC, 0, byte address fetched first after reset

Ports:
CLK  in  1  system clock; all state changes on posedge
RESET  in  1  synchronous, active-high reset
IMEM_ADDR  out  PC_W  byte address to instruction RAM; always even; equals PC
IMEM_Q  in  16  instruction word, combinational from IMEM_ADDR in the same cycle
REDIRECT_VALID  in  1  execute requests a PC change (taken branch)
REDIRECT_ADDR  in  PC_W  new byte address; bit 0 ignored (forced to 0)
ID_READY  in  1  decode accepts INSTR this cycle
INSTR  out  16  fetched instruction
INSTR_PC  out  PC_W  byte address of INSTR
INSTR_VALID  out  1  INSTR/INSTR_PC are valid
HALTED  out  1  self-loop JUMP fetched; fetching stopped
BAD_JUMP  out  1  sticky; a JUMP target had bits [11:9] nonzero

Behaviour:
- Reset: PC=RESET_PC, INSTR=16'h0000, INSTR_PC=0, INSTR_VALID=0, HALTED=0, BAD_JUMP=0. Instruction RAM loads on the same reset edges, so the first fetch happens in the first cycle after RESET deasserts. RESET during operation discards everything, including a pending redirect.
- State: RUN and HALT.
- Advance condition: adv = !HALTED && (!INSTR_VALID || ID_READY).
- Priority each cycle: RESET > REDIRECT_VALID > adv > hold.
- Redirect:
  - PC <= {REDIRECT_ADDR[PC_W-1:1],1'b0}; INSTR_VALID <= 0 (flush); HALTED <= 0.
  - The instruction currently on IMEM_Q is not captured.
  - If ID_READY is high in the same cycle, the old INSTR counts as consumed.
- Advance:
  - INSTR <= IMEM_Q; INSTR_PC <= PC; INSTR_VALID <= 1.
  - Next PC: if IMEM_Q[15:12]==4'b0001 (JUMP), PC <= {IMEM_Q[8:0],1'b0}; otherwise PC <= PC+2, wrapping modulo 2^PC_W (0x3FE -> 0x000).
  - JUMP with IMEM_Q[11:9]!=0: target is masked to 9 bits and BAD_JUMP <= 1 (cleared only by RESET).
  - JUMP whose target word equals PC[PC_W-1:1]: the word is still delivered, PC stays, HALTED <= 1, state -> HALT.
- Hold (valid && !ID_READY): INSTR, INSTR_PC, INSTR_VALID and PC are all stable.
- HALT state:
  - No further capture.
  - INSTR_VALID drops once decode accepts the pending word (ID_READY while valid -> INSTR_VALID <= 0).
  - Exit only on REDIRECT_VALID or RESET.
- Branch opcodes (1000 BEQ, 1001 BNE, 1010 BGEZ, 1011 BLTZ) are not interpreted here; fetch continues sequentially until a redirect arrives.
- Latency: 1 cycle from IMEM_ADDR presentation to INSTR_VALID. Sustained throughput is 1 word/cycle, including across JUMPs.
- IMEM_ADDR is combinational from PC only, never from IMEM_Q.

Decomposition:
- Shared package cpu_isa_pkg:
  - opcode constants OP_JUMP=4'b0001, OP_LB=4'b0010, OP_SB=4'b0100, OP_ADDI=4'b0101, OP_ORI=4'b0111, OP_BEQ=4'b1000, OP_BNE=4'b1001, OP_BGEZ=4'b1010, OP_BLTZ=4'b1011, OP_RTYPE=4'b1111
  - IMEM_WORDS=512; PC width constant.
- One sub-module, jump_predecode (combinational):
  - input: 16-bit word and PC
  - outputs: is_jump, target byte address, bad_target, self_loop.

Test Plan:
1. Reset 3 cycles, straight-line ADDs at words 0..3, ID_READY=1 -> INSTR_PC sequence 0x000, 0x002, 0x004, 0x006; INSTR_VALID rises the first cycle after reset.
2. Word 10 = 16'h1021 (JUMP 33) -> next captured INSTR_PC = 0x042 the following cycle, no bubble.
3. ID_READY=0 for 4 cycles while valid -> INSTR, INSTR_PC, IMEM_ADDR stable; capture resumes the cycle ID_READY returns.
4. REDIRECT_VALID with REDIRECT_ADDR=0x03F, in the same cycle as ID_READY=0 -> INSTR_VALID=0 next cycle, IMEM_ADDR=0x03E, then INSTR_PC=0x03E.
5. Word 157 = 16'h109D (JUMP 157) -> one valid word with INSTR_PC=0x13A, HALTED=1, INSTR_VALID=0 after acceptance, IMEM_ADDR held at 0x13A; a later redirect to 0 clears HALTED.
6. JUMP word 16'h1E05 -> BAD_JUMP=1, PC=0x00A; RESET mid-stall -> all outputs return to reset values next cycle.
